// File: rtl/block_loader.sv
// Byte-serial loader that packs 16 bytes into 128-bit blocks in two ping-pong slots and hands them out over valid/ready.
// Optional LOADER_PAD_EN: in_last closes a short block and zero-pads its remaining bytes.
module block_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [9:0]   cfg_key,
  input  logic         cfg_mode,
  output logic [127:0] blk_data,
  output logic [9:0]   blk_key,
  output logic         blk_mode,
  output logic [4:0]   blk_nbytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [1:0]   pending
);

  logic       wr_slot_reg;
  logic       rd_slot_reg;
  logic [3:0] byte_idx_reg;
  logic [1:0] full_vec;
  logic       accept;
  logic       consume;
  logic       last_hit;
  logic       close;
  logic [4:0] close_count;

`ifdef LOADER_PAD_EN
  assign last_hit = in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign last_hit       = 1'b0;
`endif

  assign in_ready    = !full_vec[wr_slot_reg];
  assign blk_valid   = full_vec[rd_slot_reg];
  assign accept      = in_valid && in_ready;
  assign consume     = blk_valid && blk_ready;
  assign close       = accept && ((byte_idx_reg == 4'hF) || last_hit);
  assign close_count = {1'b0, byte_idx_reg} + 5'd1;
  assign pending     = {1'b0, full_vec[0]} + {1'b0, full_vec[1]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [127:0] data_reg;
      logic [127:0] data_next;
      logic [9:0]   key_reg;
      logic         mode_reg;
      logic [4:0]   nbytes_reg;
      logic         full_reg;
      logic         wr_sel;
      logic         rd_sel;

      assign wr_sel       = accept && (wr_slot_reg == 1'(gi));
      assign rd_sel       = consume && (rd_slot_reg == 1'(gi));
      assign full_vec[gi] = full_reg;

      // Merge the incoming byte; on an early close the tail is zeroed in the same edge.
      always_comb begin
        data_next = data_reg;
        for (int b = 0; b < 16; b++) begin
          if (4'(b) == byte_idx_reg)
            data_next[127 - 8*b -: 8] = in_data;
          else if (close && (4'(b) > byte_idx_reg))
            data_next[127 - 8*b -: 8] = 8'h00;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg   <= '0;
          key_reg    <= '0;
          mode_reg   <= 1'b0;
          nbytes_reg <= '0;
          full_reg   <= 1'b0;
        end else begin
          if (wr_sel) begin
            data_reg <= data_next;
            if (byte_idx_reg == 4'h0) begin
              key_reg  <= cfg_key;
              mode_reg <= cfg_mode;
            end
            if (close) begin
              nbytes_reg <= close_count;
              full_reg   <= 1'b1;
            end
          end else if (rd_sel) begin
            full_reg <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign blk_data   = rd_slot_reg ? g_slot[1].data_reg   : g_slot[0].data_reg;
  assign blk_key    = rd_slot_reg ? g_slot[1].key_reg    : g_slot[0].key_reg;
  assign blk_mode   = rd_slot_reg ? g_slot[1].mode_reg   : g_slot[0].mode_reg;
  assign blk_nbytes = rd_slot_reg ? g_slot[1].nbytes_reg : g_slot[0].nbytes_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_slot_reg  <= 1'b0;
      rd_slot_reg  <= 1'b0;
      byte_idx_reg <= 4'h0;
    end else begin
      if (accept) begin
        if (close) begin
          byte_idx_reg <= 4'h0;
          wr_slot_reg  <= !wr_slot_reg;
        end else begin
          byte_idx_reg <= byte_idx_reg + 4'h1;
        end
      end
      if (consume)
        rd_slot_reg <= !rd_slot_reg;
    end
  end

endmodule
